// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte producers.
// Define UART_ARB_LOCK_EN to let a locked owner keep the channel across back-to-back bytes.
module uart_tx_arbiter #(
    parameter int DBIT   = 8,
    parameter int N_REQ  = 4,
    parameter int NB_REQ = 2
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic [N_REQ-1:0]      i_req,
    input  logic [N_REQ*DBIT-1:0] i_data,
    input  logic [N_REQ-1:0]      i_lock,
    input  logic                  i_tx_done_tick,
    output logic                  o_tx_start,
    output logic [DBIT-1:0]       o_tx_data,
    output logic [N_REQ-1:0]      o_ack,
    output logic [N_REQ-1:0]      o_grant,
    output logic                  o_busy
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_START     = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [NB_REQ-1:0] last_q, last_d;
    logic [NB_REQ-1:0] winner_q, winner_d;
    logic [DBIT-1:0]   data_q, data_d;

    logic [DBIT-1:0]   data_arr [N_REQ];
    logic [NB_REQ-1:0] rr_idx;
    logic              rr_found;
    logic [N_REQ-1:0]  winner_oh;

    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            data_arr[k] = i_data[k*DBIT +: DBIT];
        end
    end

    // Search last+1, last+2, ... modulo N_REQ; first pending request wins.
    always_comb begin : rr_search
        int                cand;
        logic [NB_REQ-1:0] cand_idx;
        cand     = 0;
        cand_idx = '0;
        rr_idx   = '0;
        rr_found = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand     = (int'(last_q) + k) % N_REQ;
            cand_idx = NB_REQ'(cand);
            if (!rr_found && i_req[cand_idx]) begin
                rr_found = 1'b1;
                rr_idx   = cand_idx;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        winner_d = winner_q;
        data_d   = data_q;
        case (state_q)
            S_IDLE: begin
                if (rr_found) begin
                    winner_d = rr_idx;
                    data_d   = data_arr[rr_idx];
                    state_d  = S_START;
                end
            end
            S_START: begin
                state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (i_tx_done_tick) begin
`ifdef UART_ARB_LOCK_EN
                    if (i_lock[winner_q] && i_req[winner_q]) begin
                        data_d  = data_arr[winner_q];
                        state_d = S_START;
                    end else begin
                        last_d  = winner_q;
                        state_d = S_IDLE;
                    end
`else
                    last_d  = winner_q;
                    state_d = S_IDLE;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifndef UART_ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = ^i_lock;
`endif

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= S_IDLE;
            last_q   <= NB_REQ'(N_REQ - 1);
            winner_q <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            winner_q <= winner_d;
            data_q   <= data_d;
        end
    end

    // Outputs decode registered state only, so reset clears them immediately.
    assign winner_oh  = N_REQ'(1) << winner_q;
    assign o_tx_start = (state_q == S_START);
    assign o_ack      = (state_q == S_START) ? winner_oh : '0;
    assign o_grant    = (state_q != S_IDLE) ? winner_oh : '0;
    assign o_busy     = (state_q != S_IDLE);
    assign o_tx_data  = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: vector table, directed corner sequences
// and a randomized run against a transaction-level round-robin model.
module tb_uart_tx_arbiter;
    localparam int DBIT   = 8;
    localparam int N_REQ  = 4;
    localparam int NB_REQ = 2;

`ifdef UART_ARB_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic [3:0]  i_req;
    logic [31:0] i_data;
    logic [3:0]  i_lock;
    logic        i_tx_done_tick;
    logic        o_tx_start;
    logic [7:0]  o_tx_data;
    logic [3:0]  o_ack;
    logic [3:0]  o_grant;
    logic        o_busy;

    int n_checks = 0;
    int n_err    = 0;

    uart_tx_arbiter #(.DBIT(DBIT), .N_REQ(N_REQ), .NB_REQ(NB_REQ)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_req(i_req), .i_data(i_data),
        .i_lock(i_lock), .i_tx_done_tick(i_tx_done_tick), .o_tx_start(o_tx_start),
        .o_tx_data(o_tx_data), .o_ack(o_ack), .o_grant(o_grant), .o_busy(o_busy)
    );

    always #5 i_clock = ~i_clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Invariants: one start per ack, grant one-hot or zero.
    always @(negedge i_clock) begin
        if (i_reset === 1'b0) begin
            check("start_vs_ack", {31'd0, o_tx_start}, {31'd0, |o_ack});
            check("grant_onehot0", {31'd0, $onehot0(o_grant)}, 32'd1);
        end
    end

    function automatic int oh_idx(input logic [3:0] v);
        for (int k = 0; k < 4; k++) if (v == (4'b1 << k)) return k;
        return -1;
    endfunction

    function automatic logic [7:0] slice(input logic [31:0] d, input int k);
        logic [31:0] t;
        t = d >> (8 * k);
        return t[7:0];
    endfunction

    task automatic do_reset();
        i_reset = 1'b1;
        i_req = '0; i_data = '0; i_lock = '0; i_tx_done_tick = 1'b0;
        repeat (2) @(posedge i_clock);
        #1 i_reset = 1'b0;
    endtask

    // Sitting at posedge+1; returns when o_tx_start is high, cyc = edges waited.
    task automatic wait_start(output int idx, output int cyc);
        cyc = 0;
        while (!o_tx_start && cyc < 50) begin
            @(posedge i_clock); #1;
            cyc++;
        end
        if (!o_tx_start) begin
            check("start_timeout", 32'd0, 32'd1);
            idx = -1;
        end else begin
            idx = oh_idx(o_ack);
        end
    endtask

    task automatic pulse_done();
        i_tx_done_tick = 1'b1;
        @(posedge i_clock); #1;
        i_tx_done_tick = 1'b0;
    endtask

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic       exp_start;
        logic [3:0] exp_ack;
        logic [3:0] exp_grant;
        logic       exp_busy;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [15];

    // Reference model state: owner is -1 when the channel is free.
    int         m_owner, m_last;
    bit         m_fresh;
    logic [7:0] m_data;

    function automatic int rr_pick(input logic [3:0] req, input int last);
        for (int k = 1; k <= N_REQ; k++) if (req[(last + k) % N_REQ]) return (last + k) % N_REQ;
        return -1;
    endfunction

    task automatic model_step();
        bit hold;
        if (m_owner < 0) begin
            if (i_req != 0) begin
                m_owner = rr_pick(i_req, m_last);
                m_data  = slice(i_data, m_owner);
                m_fresh = 1'b1;
            end
        end else if (m_fresh) begin
            m_fresh = 1'b0;
        end else if (i_tx_done_tick) begin
            hold = LOCK_EN && i_lock[m_owner] && i_req[m_owner];
            if (hold) begin
                m_data  = slice(i_data, m_owner);
                m_fresh = 1'b1;
            end else begin
                m_last  = m_owner;
                m_owner = -1;
            end
        end
    endtask

    initial begin
        int idx, cyc;
        int exp_order [4];
        int exp_gap [4];
        logic [3:0] eg;

        vecs[0]  = '{4'b0001, 1'b0, 1'b1, 4'b0001, 4'b0001, 1'b1, 8'h55};
        vecs[1]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0001, 1'b1, 8'h55};
        vecs[2]  = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b0001, 1'b1, 8'h55};
        vecs[3]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h55};
        vecs[4]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h55};
        vecs[5]  = '{4'b1111, 1'b0, 1'b1, 4'b0010, 4'b0010, 1'b1, 8'h20};
        vecs[6]  = '{4'b1111, 1'b0, 1'b0, 4'b0000, 4'b0010, 1'b1, 8'h20};
        vecs[7]  = '{4'b1111, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h20};
        vecs[8]  = '{4'b1111, 1'b0, 1'b1, 4'b0100, 4'b0100, 1'b1, 8'h33};
        vecs[9]  = '{4'b0001, 1'b1, 1'b0, 4'b0000, 4'b0100, 1'b1, 8'h33};
        vecs[10] = '{4'b0001, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h33};
        vecs[11] = '{4'b1001, 1'b0, 1'b1, 4'b1000, 4'b1000, 1'b1, 8'h44};
        vecs[12] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 4'b1000, 1'b1, 8'h44};
        vecs[13] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 4'b0000, 1'b0, 8'h44};
        vecs[14] = '{4'b1010, 1'b0, 1'b1, 4'b0010, 4'b0010, 1'b1, 8'h20};

        do_reset();
        check("rst_start", {31'd0, o_tx_start}, 32'd0);
        check("rst_ack",   {28'd0, o_ack},      32'd0);
        check("rst_grant", {28'd0, o_grant},    32'd0);
        check("rst_busy",  {31'd0, o_busy},     32'd0);
        check("rst_data",  {24'd0, o_tx_data},  32'd0);

        i_data = 32'h4433_2055;
        for (int i = 0; i < 15; i++) begin
            i_req = vecs[i].req;
            i_tx_done_tick = vecs[i].done;
            @(posedge i_clock); #1;
            check($sformatf("vec%0d.start", i), {31'd0, o_tx_start}, {31'd0, vecs[i].exp_start});
            check($sformatf("vec%0d.ack", i),   {28'd0, o_ack},      {28'd0, vecs[i].exp_ack});
            check($sformatf("vec%0d.grant", i), {28'd0, o_grant},    {28'd0, vecs[i].exp_grant});
            check($sformatf("vec%0d.busy", i),  {31'd0, o_busy},     {31'd0, vecs[i].exp_busy});
            check($sformatf("vec%0d.data", i),  {24'd0, o_tx_data},  {24'd0, vecs[i].exp_data});
        end
        i_req = '0; i_tx_done_tick = 1'b0;

        // Fairness: all four requesting, strict rotation and a two-cycle done-to-start gap.
        do_reset();
        i_req  = 4'b1111;
        i_data = 32'h0403_0201;
        for (int k = 0; k < 5; k++) begin
            wait_start(idx, cyc);
            check($sformatf("fair%0d.idx", k), idx, k % 4);
            check($sformatf("fair%0d.data", k), {24'd0, o_tx_data}, (k % 4) + 1);
            if (k > 0) check($sformatf("fair%0d.gap", k), cyc + 1, 2);
            repeat (3) @(posedge i_clock);
            #1 pulse_done();
        end
        i_req = '0;

        // Late arrival during WAIT_DONE; latched byte must not follow i_data.
        do_reset();
        i_data = 32'h4433_2011;
        i_req  = 4'b0010;
        wait_start(idx, cyc);
        check("late.first", idx, 1);
        @(posedge i_clock); #1;
        i_req  = 4'b0110;
        i_data = 32'h4433_AA11;
        for (int k = 0; k < 3; k++) begin
            @(posedge i_clock); #1;
            check($sformatf("late.hold%0d", k), {24'd0, o_tx_data}, 32'h20);
            check($sformatf("late.grant%0d", k), {28'd0, o_grant}, 32'b0010);
        end
        pulse_done();
        check("late.busy_drop", {31'd0, o_busy}, 32'd0);
        wait_start(idx, cyc);
        check("late.next", idx, 2);
        check("late.next_data", {24'd0, o_tx_data}, 32'h33);
        i_req = '0;
        repeat (2) @(posedge i_clock);
        #1 pulse_done();

        // Asynchronous reset in WAIT_DONE clears outputs before the next edge.
        i_req  = 4'b0100;
        wait_start(idx, cyc);
        repeat (2) @(posedge i_clock);
        #2 i_reset = 1'b1;
        i_req = 4'b1010;
        #1;
        check("arst.start", {31'd0, o_tx_start}, 32'd0);
        check("arst.ack",   {28'd0, o_ack},      32'd0);
        check("arst.grant", {28'd0, o_grant},    32'd0);
        check("arst.busy",  {31'd0, o_busy},     32'd0);
        check("arst.data",  {24'd0, o_tx_data},  32'd0);
        @(posedge i_clock);
        #1 i_reset = 1'b0;
        wait_start(idx, cyc);
        check("arst.first", idx, 1);
        i_req = '0;
        repeat (2) @(posedge i_clock);
        #1 pulse_done();

        // Lock: requester 3 holds the channel for three bytes when the feature is built in.
        if (LOCK_EN) begin
            exp_order = '{3, 3, 3, 0};
            exp_gap   = '{0, 1, 1, 2};
        end else begin
            exp_order = '{3, 0, 1, 3};
            exp_gap   = '{0, 2, 2, 2};
        end
        do_reset();
        i_lock = 4'b1000;
        i_req  = 4'b1000;
        i_data = 32'hC033_2211;
        for (int k = 0; k < 4; k++) begin
            wait_start(idx, cyc);
            check($sformatf("lock%0d.idx", k), idx, exp_order[k]);
            check($sformatf("lock%0d.data", k), {24'd0, o_tx_data}, {24'd0, slice(i_data, exp_order[k])});
            if (k > 0) check($sformatf("lock%0d.gap", k), cyc + 1, exp_gap[k]);
            if (k == 0) i_req = 4'b1011;
            repeat (2) @(posedge i_clock);
            #1;
            if (k == 2) i_lock = 4'b0000;
            i_data[31:24] = 8'hC1 + 8'(k);
            pulse_done();
        end

        // Randomized traffic against the transaction-level model.
        do_reset();
        m_owner = -1; m_last = N_REQ - 1; m_fresh = 1'b0; m_data = '0;
        for (int t = 0; t < 600; t++) begin
            i_req  = 4'($urandom);
            i_data = $urandom;
            i_lock = 4'($urandom);
            i_tx_done_tick = ($urandom_range(0, 3) == 0);
            @(posedge i_clock);
            model_step();
            #1;
            eg = (m_owner >= 0) ? (4'b1 << m_owner) : 4'b0;
            check("rnd.start", {31'd0, o_tx_start}, {31'd0, m_fresh});
            check("rnd.ack",   {28'd0, o_ack},      m_fresh ? {28'd0, eg} : 32'd0);
            check("rnd.grant", {28'd0, o_grant},    {28'd0, eg});
            check("rnd.busy",  {31'd0, o_busy},     (m_owner >= 0) ? 32'd1 : 32'd0);
            check("rnd.data",  {24'd0, o_tx_data},  {24'd0, m_data});
        end

        i_req = '0; i_tx_done_tick = 1'b0;
        @(posedge i_clock); #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
